// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI constants, FSM state type and master chip-select encodings.
package spi_pkg;
    localparam int SPI_DATA_WIDTH = 8;
    typedef enum logic {IDLE, SHIFT} state_t;
    localparam logic [2:0] CS_SLV0 = 3'b110;
    localparam logic [2:0] CS_SLV1 = 3'b101;
    localparam logic [2:0] CS_SLV2 = 3'b011;
    localparam logic [2:0] CS_IDLE = 3'b111;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: STAGES-flop synchronizer; edges compare the last stage with one delay flop.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);
    logic [STAGES-1:0] sync_q;
    logic              dly_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= {STAGES{RST_VAL}};
            dly_q  <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            dly_q  <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = q_o & ~dly_q;
    assign fall_o = ~q_o & dly_q;
endmodule

// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: SPI mode-0 slave on the system clock with oversampled pins.
// Define SPI_SLAVE_CTRL_FRAME_CNT_EN to add the frame_count output.
module spi_slave_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter bit LSB_FIRST   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  SCLK,
    input  logic                  CS,
    input  logic                  MOSI,
    output logic                  MISO,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  tx_underrun
`ifdef SPI_SLAVE_CTRL_FRAME_CNT_EN
    ,
    output logic [15:0]           frame_count
`endif
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [DATA_WIDTH-1:0]  tx_sh_q, rx_sh_q, rx_data_q, tx_sh_d, rx_sh_d;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   miso_q, tx_ready_q, rx_valid_q, done_q, underrun_q;
    logic                   sclk_rise, sclk_fall, sclk_unused, cs_s, cs_rise, cs_fall, load;

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] v);
        return LSB_FIRST ? v[0] : v[DATA_WIDTH-1];
    endfunction

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .reset(reset), .d_i(SCLK), .q_o(sclk_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(clk), .reset(reset), .d_i(CS), .q_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    always_ff @(posedge clk) begin
        mosi_q <= !reset ? '0 : {mosi_q[SYNC_STAGES-2:0], MOSI};
    end

    always_comb begin
        tx_sh_d = LSB_FIRST ? tx_sh_q >> 1 : tx_sh_q << 1;
        rx_sh_d = LSB_FIRST ? {mosi_q[SYNC_STAGES-1], rx_sh_q[DATA_WIDTH-1:1]}
                            : {rx_sh_q[DATA_WIDTH-2:0], mosi_q[SYNC_STAGES-1]};
        // A fall with the counter at 0 starts the next frame without a CS toggle
        load    = state_q == IDLE ? cs_fall : sclk_fall && !cs_rise && cnt_q == '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            miso_q     <= 1'b0;
            tx_ready_q <= 1'b0;
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            tx_ready_q <= load && tx_valid;
            rx_valid_q <= done_q;
            done_q     <= 1'b0;
            if (done_q) rx_data_q <= rx_sh_q;
            if (load) begin
                tx_sh_q    <= tx_valid ? tx_data : '0;
                miso_q     <= tx_valid && first_bit(tx_data);
                underrun_q <= underrun_q || !tx_valid;
            end
            if (state_q == IDLE) begin
                if (cs_fall) begin
                    cnt_q   <= '0;
                    state_q <= SHIFT;
                end else begin
                    miso_q <= 1'b0;
                end
            end else begin
                if (sclk_rise) begin
                    rx_sh_q <= rx_sh_d;
                    cnt_q   <= cnt_q == CW'(DATA_WIDTH - 1) ? '0 : cnt_q + 1'b1;
                    done_q  <= cnt_q == CW'(DATA_WIDTH - 1);
                end
                if (sclk_fall && !load) begin
                    tx_sh_q <= tx_sh_d;
                    miso_q  <= first_bit(tx_sh_d);
                end
                // A final-bit rise in the same cycle still completes via done_q
                if (cs_rise) begin
                    state_q <= IDLE;
                    miso_q  <= 1'b0;
                end
            end
        end
    end

    assign MISO        = miso_q;
    assign tx_ready    = tx_ready_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign busy        = ~cs_s;
    assign tx_underrun = underrun_q;

`ifdef SPI_SLAVE_CTRL_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) frame_cnt_q <= '0;
        else if (rx_valid_q) frame_cnt_q <= frame_cnt_q + 16'd1;
    end

    assign frame_count = frame_cnt_q;
`endif
endmodule

// File: doc/spi_slave_ctrl.md
Name: spi_slave_ctrl

Overview:
SPI slave endpoint that sits directly downstream of the team's SPI master and consumes its SCLK/CS/MOSI lines. It drives MISO back.
- Runs entirely on the slave's own system clock; SCLK is oversampled.
- Received bytes are presented to local logic as one-cycle valid pulses.
- Transmit bytes are fetched from local logic through a valid/ready handshake.
- SPI mode 0 (CPOL=0, CPHA=0): MOSI sampled on SCLK rise, MISO updated on SCLK fall.

Parameters:
- DATA_WIDTH, 8, bits per SPI frame
- SYNC_STAGES, 2, synchronizer flops on SCLK, CS and MOSI (minimum 2)
- LSB_FIRST, 1, 1 = bit 0 shifted first on both MOSI and MISO (matches master); 0 = MSB first

Ports:
- clk  input  1  system clock; SCLK must be at most clk/4
- reset  input  1  synchronous reset, active-low
- SCLK  input  1  serial clock from master
- CS  input  1  this slave's chip select, active-low (one bit of the master's CS bus)
- MOSI  input  1  serial data from master
- MISO  output  1  serial data to master
- tx_data  input  DATA_WIDTH  next byte to transmit
- tx_valid  input  1  tx_data is valid
- tx_ready  output  1  one-cycle pulse: tx_data was consumed this cycle
- rx_data  output  DATA_WIDTH  last complete received byte, held until the next one
- rx_valid  output  1  one-cycle pulse: rx_data updated
- busy  output  1  high while CS is asserted (synchronized view)
- tx_underrun  output  1  sticky: a frame was loaded while tx_valid=0

Behaviour:
- Interface is decided: one clock `clk`; `reset` is synchronous and active-low.
- Reset (reset=0 at a clk edge) clears the following to 0: MISO, tx_ready, rx_data, rx_valid, busy, tx_underrun, bit counter, both shift registers. State goes to IDLE.
- Input sync: SCLK, CS and MOSI each pass through SYNC_STAGES flops. Edges are detected by comparing the last sync stage with one extra delay flop.
- Pin-to-edge-event latency is SYNC_STAGES+1 clk.
- IDLE:
  - MISO held 0.
  - On a synchronized CS falling edge: load tx shift reg, drive first bit on MISO, clear bit counter, go to SHIFT.
- Load rule:
  - If tx_valid=1: load tx_data and pulse tx_ready for one cycle.
  - Else: load all zeros and set tx_underrun. tx_ready stays 0.
- SHIFT, SCLK rise: shift the synchronized MOSI into the rx shift reg and increment the bit counter.
  - When the counter reaches DATA_WIDTH: on the next clk, rx_data gets the assembled frame and rx_valid pulses for 1 cycle. The counter wraps to 0.
- SHIFT, SCLK fall: present the next tx bit on MISO.
  - If the counter just wrapped to 0, perform the load rule first, so back-to-back frames need no CS toggle.
- Bit order: LSB_FIRST=1 means tx bit 0 goes out first, and the first received bit lands in rx_data[0]. LSB_FIRST=0 mirrors both.
- CS rising edge in SHIFT:
  - Return to IDLE and set MISO to 0.
  - A partial frame is discarded (no rx_valid). A partially sent tx byte is dropped, not re-sent.
- CS rise coinciding with a final-bit SCLK rise: the byte completes; rx_valid is still issued, then IDLE.
- SCLK edges while CS is deasserted are ignored.
- tx_underrun clears only on reset.
- busy equals the inverted synchronized CS.

Optional Feature:
- Macro: SPI_SLAVE_CTRL_FRAME_CNT_EN.
- Defined: adds output frame_count [15:0]. It increments on every rx_valid, wraps 0xFFFF to 0x0000, resets to 0, and is not cleared by CS.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package spi_pkg:
  - SPI_DATA_WIDTH = 8
  - state typedef {IDLE, SHIFT}
  - CS one-hot-low encodings used by the master (3'b110, 3'b101, 3'b011, idle 3'b111)
- One natural sub-module: spi_sync_edge. It is a parameterised SYNC_STAGES synchronizer with rise/fall pulse outputs, instantiated for SCLK and CS (MOSI uses the sync path only).

Test Plan:
- Reset: hold reset=0 with random pin activity → MISO, rx_valid, tx_ready, busy, tx_underrun all 0; rx_data=0x00.
- Single frame: tx_data=0x3C, tx_valid=1; master sends 0xA5 LSB-first at clk/8 → tx_ready pulses once at CS fall; MISO bit sequence 0,0,1,1,1,1,0,0; rx_data=0xA5 with a single rx_valid pulse.
- Back-to-back frames: CS held low over 16 SCLKs carrying 0x01 then 0x80; tx bytes 0x11, 0x22 → two rx_valid pulses (0x01, 0x80); second tx_ready at the 8th SCLK fall; MISO carries 0x11 then 0x22.
- Underrun: tx_valid=0 at CS fall → MISO all 0; tx_underrun=1 and stays 1 after CS rise; rx path still yields the byte.
- Abort: CS rises after 5 SCLKs → no rx_valid; busy falls; next full frame 0x5A is received correctly from bit 0.
- Bit order: LSB_FIRST=0, master sends 0xC1 MSB-first → rx_data=0xC1. With SPI_SLAVE_CTRL_FRAME_CNT_EN, 3 frames → frame_count=3.
